// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the sequential ALU:
//   - opcode constants, including the casez patterns of the immediate forms
//     (the low nibble of an immediate opcode is don't-care here because the
//     operand arrives already extended on a_i)
//   - bit positions of the five flags in the flag register
//   - the control state type of the top level
package alu_pkg;

    // Register-register forms
    localparam logic [7:0] OP_WAIT    = 8'b0000_0000;
    localparam logic [7:0] OP_AND     = 8'b0000_0001;
    localparam logic [7:0] OP_OR      = 8'b0000_0010;
    localparam logic [7:0] OP_XOR     = 8'b0000_0011;
    localparam logic [7:0] OP_ADDCU   = 8'b0000_0100;
    localparam logic [7:0] OP_ADD     = 8'b0000_0101;
    localparam logic [7:0] OP_ADDU    = 8'b0000_0110;
    localparam logic [7:0] OP_ADDC    = 8'b0000_0111;
    localparam logic [7:0] OP_CMPU    = 8'b0000_1000;
    localparam logic [7:0] OP_SUB     = 8'b0000_1001;
    localparam logic [7:0] OP_CMP     = 8'b0000_1011;
    localparam logic [7:0] OP_NOT     = 8'b0000_1100;
    localparam logic [7:0] OP_MOV     = 8'b0000_1101;
    localparam logic [7:0] OP_MUL     = 8'b0000_1110;
    localparam logic [7:0] OP_START   = 8'b0000_1111;
    localparam logic [7:0] OP_ASH     = 8'b0100_1111;
    localparam logic [7:0] OP_LSH     = 8'b1000_0100;
    localparam logic [7:0] OP_GET     = 8'b1000_0101;

    // Immediate forms (casez patterns)
    localparam logic [7:0] OP_ADDCU_I = 8'b0001_????;
    localparam logic [7:0] OP_CMPU_I  = 8'b0010_????;
    localparam logic [7:0] OP_MOV_I   = 8'b0011_????;
    localparam logic [7:0] OP_ADD_I   = 8'b0101_????;
    localparam logic [7:0] OP_ADDU_I  = 8'b0110_????;
    localparam logic [7:0] OP_ADDC_I  = 8'b0111_????;
    localparam logic [7:0] OP_LSH_I   = 8'b1000_000?;
    localparam logic [7:0] OP_ASH_I   = 8'b1000_001?;
    localparam logic [7:0] OP_SUB_I   = 8'b1001_????;
    localparam logic [7:0] OP_AND_I   = 8'b1010_????;
    localparam logic [7:0] OP_CMP_I   = 8'b1011_????;

    // Flag register bit positions
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;
    localparam int NUM_FLAGS = 5;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk_i            system clock, rising edge
//   rst_ni           asynchronous active-low reset, abandons any product
//   start_i          load operands and begin (ignored unless idle upstream)
//   multiplicand_i   first operand
//   multiplier_i     second operand
//   done_o           high in the cycle whose closing edge completes the
//                    last iteration; product_o is final in that cycle
//   product_o        full 2*WIDTH product (combinational view of the
//                    accumulator after the current iteration)
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH + 1);
    typedef logic [CW-1:0] cnt_t;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    cnt_t               cnt_q, cnt_d;
    logic               running_q, running_d;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] stepAcc;

    // The accumulator starts as {0, multiplier}. Each step adds the
    // multiplicand into the upper half when the current low bit is set and
    // shifts the whole thing right, so the multiplier bits are consumed from
    // the bottom while the product grows in from the top.
    always_comb begin
        partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        stepAcc = {partial, acc_q[WIDTH-1:1]};
    end

    // Load on start, otherwise iterate until the counter reaches its last step.
    always_comb begin
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        running_d = running_q;
        if (start_i) begin
            acc_d     = {{WIDTH{1'b0}}, multiplier_i};
            mcand_d   = multiplicand_i;
            cnt_d     = cnt_t'(WIDTH);
            running_d = 1'b1;
        end else if (running_q) begin
            acc_d = stepAcc;
            cnt_d = cnt_q - cnt_t'(1);
            if (cnt_q == cnt_t'(1)) begin
                running_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
        end
    end

    assign done_o    = running_q && (cnt_q == cnt_t'(1));
    assign product_o = stepAcc;

endmodule

// File: rtl/alu_seq_module.sv
// alu_seq_module
// Registered ALU with a persistent flag register and an optional iterative
// unsigned multiply. Sits between register read and write-back.
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   op_valid_i   operation presented this cycle
//   op_ready_o   operation can be accepted (low while a multiply runs)
//   opcode_i     operation code
//   a_i          source operand / signed shift amount
//   b_i          destination operand
//   flag_clr_i   synchronous clear of the flag register (beats any update)
//   res_valid_o  one-cycle pulse: res_o and flags_o are fresh
//   res_o        registered result
//   flags_o      flag register {N, Z, F, L, C}
//   busy_o       multiply in progress
module alu_seq_module
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [7:0]       opcode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flag_clr_i,
    output logic             res_valid_o,
    output logic [WIDTH-1:0] res_o,
    output logic [4:0]       flags_o,
    output logic             busy_o
);

    typedef logic [WIDTH-1:0] word_t;

    state_e               state_q, state_d;
    word_t                res_q, res_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic                 resValid_q, resValid_d;

    word_t                decRes;
    logic [NUM_FLAGS-1:0] decFlags;
    logic                 isMul;
    logic                 accept;
    logic                 mulStart;
    logic                 mulDone;
    logic [2*WIDTH-1:0]   mulProd;

    logic [WIDTH:0]       sumPlain, sumCarry, diff;
    logic                 ovfPlain, ovfCarry, ovfSub;
    logic                 shiftNeg, shiftBig;
    word_t                shiftMag, shlRes, shrRes, sarRes, lshRes, ashRes;

    // Arithmetic datapath shared by the add/sub opcodes. Overflow is a
    // same-sign operands / different-sign result test; for subtraction the
    // operand signs must differ instead.
    always_comb begin
        sumPlain = {1'b0, b_i} + {1'b0, a_i};
        sumCarry = sumPlain + {{WIDTH{1'b0}}, flags_q[FLAG_C]};
        diff     = {1'b0, b_i} - {1'b0, a_i};
        ovfPlain = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sumPlain[WIDTH-1] != b_i[WIDTH-1]);
        ovfCarry = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sumCarry[WIDTH-1] != b_i[WIDTH-1]);
        ovfSub   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != b_i[WIDTH-1]);
    end

    // Shifter: a_i is a signed amount. Negating the most negative value
    // yields itself, which as an unsigned magnitude is 2^(WIDTH-1) >= WIDTH,
    // so it falls into the out-of-range case without special handling.
    always_comb begin
        shiftNeg = a_i[WIDTH-1];
        shiftMag = shiftNeg ? (~a_i + word_t'(1)) : a_i;
        shiftBig = (shiftMag >= word_t'(WIDTH));
        shlRes   = b_i << shiftMag;
        shrRes   = b_i >> shiftMag;
        sarRes   = word_t'($signed(b_i) >>> shiftMag);
        if (shiftBig) begin
            lshRes = '0;
            ashRes = shiftNeg ? {WIDTH{b_i[WIDTH-1]}} : '0;
        end else begin
            lshRes = shiftNeg ? shrRes : shlRes;
            ashRes = shiftNeg ? sarRes : shlRes;
        end
    end

    // Opcode decode: result and flags a single-cycle op would commit.
    always_comb begin
        decRes   = res_q;
        decFlags = flags_q;
        isMul    = 1'b0;
        casez (opcode_i)
            OP_ADD, OP_ADD_I: begin
                decRes           = sumPlain[WIDTH-1:0];
                decFlags[FLAG_C] = sumPlain[WIDTH];
                decFlags[FLAG_F] = ovfPlain;
                decFlags[FLAG_Z] = (sumPlain[WIDTH-1:0] == '0);
                decFlags[FLAG_N] = sumPlain[WIDTH-1];
            end
            OP_ADDU, OP_ADDU_I: begin
                decRes           = sumPlain[WIDTH-1:0];
                decFlags[FLAG_C] = sumPlain[WIDTH];
                decFlags[FLAG_Z] = (sumPlain[WIDTH-1:0] == '0);
                decFlags[FLAG_N] = sumPlain[WIDTH-1];
            end
            OP_ADDC, OP_ADDC_I: begin
                decRes           = sumCarry[WIDTH-1:0];
                decFlags[FLAG_C] = sumCarry[WIDTH];
                decFlags[FLAG_F] = ovfCarry;
                decFlags[FLAG_Z] = (sumCarry[WIDTH-1:0] == '0);
                decFlags[FLAG_N] = sumCarry[WIDTH-1];
            end
            OP_ADDCU, OP_ADDCU_I: begin
                decRes           = sumCarry[WIDTH-1:0];
                decFlags[FLAG_C] = sumCarry[WIDTH];
                decFlags[FLAG_Z] = (sumCarry[WIDTH-1:0] == '0);
                decFlags[FLAG_N] = sumCarry[WIDTH-1];
            end
            OP_SUB, OP_SUB_I: begin
                decRes           = diff[WIDTH-1:0];
                decFlags[FLAG_C] = diff[WIDTH];
                decFlags[FLAG_F] = ovfSub;
                decFlags[FLAG_Z] = (diff[WIDTH-1:0] == '0);
                decFlags[FLAG_N] = diff[WIDTH-1];
            end
            OP_CMP, OP_CMP_I, OP_CMPU, OP_CMPU_I: begin
                decFlags[FLAG_N] = ($signed(a_i) > $signed(b_i));
                decFlags[FLAG_L] = (a_i > b_i);
                decFlags[FLAG_Z] = (a_i == b_i);
            end
            OP_AND, OP_AND_I: begin
                decRes           = b_i & a_i;
                decFlags[FLAG_Z] = ((b_i & a_i) == '0);
            end
            OP_OR: begin
                decRes           = b_i | a_i;
                decFlags[FLAG_Z] = ((b_i | a_i) == '0);
            end
            OP_XOR: begin
                decRes           = b_i ^ a_i;
                decFlags[FLAG_Z] = ((b_i ^ a_i) == '0);
            end
            OP_NOT: begin
                decRes           = ~a_i;
                decFlags[FLAG_Z] = (a_i == {WIDTH{1'b1}});
            end
            OP_MOV, OP_MOV_I: begin
                decRes = a_i;
            end
            OP_LSH, OP_LSH_I: begin
                decRes = lshRes;
            end
            OP_ASH, OP_ASH_I: begin
                decRes = ashRes;
            end
            OP_MUL: begin
                isMul = MUL_EN;
            end
            OP_WAIT, OP_GET, OP_START: begin
            end
            default: begin
            end
        endcase
    end

    assign accept   = op_valid_i && op_ready_o;
    assign mulStart = accept && isMul;

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_seq #(
                .WIDTH (WIDTH)
            ) u_mul (
                .clk_i          (clk_i),
                .rst_ni         (rst_ni),
                .start_i        (mulStart),
                .multiplicand_i (a_i),
                .multiplier_i   (b_i),
                .done_o         (mulDone),
                .product_o      (mulProd)
            );
        end else begin : g_no_mul
            assign mulDone = 1'b0;
            assign mulProd = '0;
        end
    endgenerate

    // Commit logic. A multiply completes in the same edge that returns the
    // block to IDLE, so the next op can be accepted while res_valid is high.
    // flag_clr is applied last so it overrides any flag update.
    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        flags_d    = flags_q;
        resValid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (isMul) begin
                        state_d = MUL_RUN;
                    end else begin
                        res_d      = decRes;
                        flags_d    = decFlags;
                        resValid_d = 1'b1;
                    end
                end
            end
            MUL_RUN: begin
                if (mulDone) begin
                    state_d          = IDLE;
                    res_d            = mulProd[WIDTH-1:0];
                    flags_d[FLAG_C]  = (mulProd[2*WIDTH-1:WIDTH] != '0);
                    flags_d[FLAG_Z]  = (mulProd[WIDTH-1:0] == '0);
                    flags_d[FLAG_N]  = mulProd[WIDTH-1];
                    resValid_d       = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flag_clr_i) begin
            flags_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            res_q      <= '0;
            flags_q    <= '0;
            resValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            res_q      <= res_d;
            flags_q    <= flags_d;
            resValid_q <= resValid_d;
        end
    end

    assign busy_o      = (state_q == MUL_RUN);
    assign op_ready_o  = ~busy_o;
    assign res_valid_o = resValid_q;
    assign res_o       = res_q;
    assign flags_o     = flags_q;

endmodule

// File: doc/alu_seq_module.md
Name: alu_seq_module

Overview:
- Parametrised, clocked successor to the combinational CPU ALU.
- Registers every result, holds a persistent flag register (the carry chain for ADDC comes from it, not an external Cin) and adds an iterative multi-cycle unsigned multiply.
- Sits between the register-file read stage and write-back; a valid/ready handshake lets the decoder stall while a multiply is in progress.

Parameters:
- WIDTH, 16, datapath width in bits (>=4).
- MUL_EN, 1, 1 = MUL implemented; 0 = MUL decodes as WAIT (no-op, no flag change).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation presented this cycle.
- op_ready  out  1  block can accept an operation.
- opcode  in  8  operation code; immediate forms carry the immediate in [3:0].
- a  in  WIDTH  source operand (shift amount for shifts; already immediate-extended upstream).
- b  in  WIDTH  destination operand.
- flag_clr  in  1  synchronous clear of the flag register.
- res_valid  out  1  one-cycle pulse: res and flags are valid.
- res  out  WIDTH  registered result.
- flags  out  5  flag register: [0] C, [1] L, [2] F overflow, [3] Z, [4] N.
- busy  out  1  multiply in progress.

Behaviour:
- Reset (reset=0, async): res=0, flags=0, res_valid=0, busy=0, op_ready=1, multiply state cleared. Reset mid-multiply aborts it and produces no res_valid.
- Accept: an op is taken on the rising edge where op_valid & op_ready. op_ready = ~busy.
- Single-cycle ops: res and flags are registered on the accept edge, so res_valid is high the following cycle. Back-to-back accepts give one result per cycle.

Opcode decode (casez):
- ADD 00000101 / 0101????: res=b+a; C=carry-out; F=signed overflow; Z=(res==0); N=res[MSB].
- ADDU 00000110 / 0110????: as ADD; F unchanged.
- ADDC 00000111 / 0111????: res=b+a+flags[0]; flags as ADD.
- ADDCU 00000100 / 0001????: res=b+a+flags[0]; flags as ADDU.
- SUB 00001001 / 1001????: res=b-a; C=borrow (a>b unsigned); F=signed overflow of b-a; Z; N.
- CMP 00001011 / 1011????: no result write (res holds previous value, res_valid still pulses). N=signed(a)>signed(b); L=a>b unsigned; Z=(a==b); C and F unchanged.
- CMPU 00001000 / 0010????: same as CMP.
- AND 00000001 / 1010????, OR 00000010, XOR 00000011: bitwise op; Z=(res==0); other flags unchanged.
- NOT 00001100: res=~a; Z updated.
- MOV 00001101 / 0011????: res=a; flags unchanged.
- LSH 10000100 / 1000000?: logical shift of b by signed a (positive = left, negative = right); |a|>=WIDTH gives res=0.
- ASH 01001111 / 1000001?: as LSH, but a right shift sign-fills; |a|>=WIDTH right gives all copies of b[MSB].
- WAIT 00000000 and undefined opcodes: res_valid pulses; res and flags unchanged.
- Opcodes 10000101 (GET) and 00001111 (START) are reserved for the timer interface and treated as WAIT here.

Multiply (MUL 00001110, MUL_EN=1):
- Shift-add, unsigned, 1 bit per cycle.
- Accept edge loads the multiplicand, multiplier and a 2*WIDTH accumulator, and sets busy=1.
- Runs WIDTH iterations; res_valid pulses exactly WIDTH+1 cycles after the accept edge.
- Result: res = low WIDTH bits. C=(high half !=0); Z=(low half==0); N=res[MSB]; F and L unchanged.
- During busy: op_ready=0 and op_valid is ignored. busy falls in the same cycle res_valid rises, so a new op can be accepted in that cycle.

Flag register:
- Updates only on the result edge of a flag-affecting op.
- flag_clr clears all flags. If flag_clr coincides with a flag-affecting result, flag_clr wins.
- ADDC/ADDCU read the flag value from before the edge.

Width rules:
- All arithmetic is WIDTH bits with one extra carry bit.
- The shift amount is interpreted as a signed WIDTH-bit value; the most negative value counts as |a|>=WIDTH.

Decomposition:
- Package alu_pkg: opcode localparams (including casez patterns), flag bit index constants (FLAG_C=0, FLAG_L=1, FLAG_F=2, FLAG_Z=3, FLAG_N=4), and a state typedef {IDLE, MUL_RUN}.
- Sub-module alu_mul_seq: iterative multiplier with start/done handshake, parametrised by WIDTH.
- The top level holds the combinational decode, result/flag registers and the handshake.

Test Plan:
- ADD a=16'h7FFF, b=16'h0001 -> next cycle res=16'h8000, flags F=1, N=1, C=0, Z=0.
- ADD a=16'hFFFF, b=16'h0001, then ADDC a=0, b=0 -> res 0 with C=1, Z=1; then res=16'h0001.
- CMP a=16'hFFFF, b=16'h0001 -> N=0, L=1, Z=0, res unchanged; then CMP a=b=5 -> Z=1.
- ASH a=-4 (16'hFFFC), b=16'h8000 -> res=16'hF800. LSH a=-20, b=16'hFFFF -> res=0.
- MUL a=300, b=300 -> busy for 16 cycles, op_ready=0, res_valid at cycle 17, res=16'h5F90, C=1. An op_valid held during busy is accepted only when busy falls.
- Assert reset at cycle 5 of a MUL -> outputs 0 immediately, no res_valid; after release, ADD a=1, b=2 -> res=3.
